// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam int unsigned FRAME_DATA_BITS  = 8;
    localparam int unsigned FRAME_SHIFT_BITS = 10;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Line conditioning: 2-flop synchronisers, ps2c deglitch filter, falling-edge pulse.
module ps2_clk_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ps2c,
    input  logic i_ps2d,
    output logic o_ps2d_sync,
    output logic o_fall_edge
);

    logic [1:0]            r_c_sync;
    logic [1:0]            r_d_sync;
    logic [FILTER_LEN-1:0] r_sr;
    logic                  r_filt;
    logic                  r_fall;
    logic                  w_filt_next;

    // Filtered level only moves once the whole window agrees.
    always_comb begin
        w_filt_next = r_filt;
        if (&r_sr) begin
            w_filt_next = 1'b1;
        end else if (~|r_sr) begin
            w_filt_next = 1'b0;
        end
    end

    // Synchronisers, filter window, filtered level and edge pulse; idle line is high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_c_sync <= 2'b11;
            r_d_sync <= 2'b11;
            r_sr     <= '1;
            r_filt   <= 1'b1;
            r_fall   <= 1'b0;
        end else begin
            r_c_sync <= {r_c_sync[0], i_ps2c};
            r_d_sync <= {r_d_sync[0], i_ps2d};
            r_sr     <= {r_sr[FILTER_LEN-2:0], r_c_sync[1]};
            r_filt   <= w_filt_next;
            r_fall   <= r_filt & ~w_filt_next;
        end
    end

    assign o_ps2d_sync = r_d_sync[1];
    assign o_fall_edge = r_fall;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: start, 8 data bits LSB first, odd parity, stop.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk_Nexys,
    input  logic       Reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] byte_dato,
    output logic       scan_done_tick,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_t                      r_state, w_state_next;
    logic [CNT_W-1:0]            r_bit_cnt, w_bit_cnt_next;
    logic [TO_W-1:0]             r_to_cnt, w_to_cnt_next;
    logic [FRAME_SHIFT_BITS-1:0] r_shift, w_shift_next;
    logic [FRAME_DATA_BITS-1:0]  r_byte, w_byte_next;
    logic                        r_tick, w_tick_next;
    logic                        r_perr, w_perr_next;
    logic                        r_ferr, w_ferr_next;
    logic                        r_busy, w_busy_next;
    logic                        w_ps2d_sync;
    logic                        w_fall_edge;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filt (
        .i_clk       (clk_Nexys),
        .i_rst       (Reset),
        .i_ps2c      (ps2c),
        .i_ps2d      (ps2d),
        .o_ps2d_sync (w_ps2d_sync),
        .o_fall_edge (w_fall_edge)
    );

    // Next-state, counters, shift register and result pulses.
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_to_cnt_next  = r_to_cnt;
        w_shift_next   = r_shift;
        w_byte_next    = r_byte;
        w_tick_next    = 1'b0;
        w_perr_next    = 1'b0;
        w_ferr_next    = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_fall_edge && rx_en && !w_ps2d_sync) begin
                    w_state_next   = ST_SHIFT;
                    w_bit_cnt_next = CNT_W'(FRAME_SHIFT_BITS);
                    w_to_cnt_next  = '0;
                end
            end
            ST_SHIFT: begin
                if (w_fall_edge) begin
                    w_shift_next   = {w_ps2d_sync, r_shift[FRAME_SHIFT_BITS-1:1]};
                    w_bit_cnt_next = r_bit_cnt - CNT_W'(1);
                    w_to_cnt_next  = '0;
                    if (r_bit_cnt == CNT_W'(1)) begin
                        w_state_next = ST_CHECK;
                    end
                end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_ferr_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_to_cnt_next = r_to_cnt + TO_W'(1);
                end
            end
            ST_CHECK: begin
                w_state_next = ST_IDLE;
                if (!r_shift[FRAME_SHIFT_BITS-1]) begin
                    w_ferr_next = 1'b1;
                end else if (!odd_parity_ok(r_shift[FRAME_DATA_BITS:0])) begin
                    w_perr_next = 1'b1;
                end else begin
                    w_byte_next = r_shift[FRAME_DATA_BITS-1:0];
                    w_tick_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_busy_next = (w_state_next != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk_Nexys or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            r_shift   <= '0;
            r_byte    <= '0;
            r_tick    <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_to_cnt  <= w_to_cnt_next;
            r_shift   <= w_shift_next;
            r_byte    <= w_byte_next;
            r_tick    <= w_tick_next;
            r_perr    <= w_perr_next;
            r_ferr    <= w_ferr_next;
            r_busy    <= w_busy_next;
        end
    end

    assign byte_dato      = r_byte;
    assign scan_done_tick = r_tick;
    assign parity_err     = r_perr;
    assign frame_err      = r_ferr;
    assign busy           = r_busy;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Randomised and directed frames against a frame-level reference model.
module tb_ps2_rx_frame;

    localparam int FL = 4;
    localparam int TO = 200;
    localparam int HP = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2c;
    logic       ps2d;
    logic       rx_en;
    logic [7:0] byte_dato;
    logic       tick;
    logic       perr;
    logic       ferr;
    logic       busy;

    always #5 clk = ~clk;

    ps2_rx_frame #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_Nexys      (clk),
        .Reset          (rst),
        .ps2c           (ps2c),
        .ps2d           (ps2d),
        .rx_en          (rx_en),
        .byte_dato      (byte_dato),
        .scan_done_tick (tick),
        .parity_err     (perr),
        .frame_err      (ferr),
        .busy           (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: counts pulses and remembers when/what they carried.
    int         n_tick  = 0;
    int         n_perr  = 0;
    int         n_ferr  = 0;
    int         n_multi = 0;
    int         tick_cyc = 0;
    int         ferr_cyc = 0;
    logic [7:0] tick_byte = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (tick) begin
                n_tick    = n_tick + 1;
                tick_cyc  = cyc;
                tick_byte = byte_dato;
            end
            if (perr) n_perr = n_perr + 1;
            if (ferr) begin
                n_ferr   = n_ferr + 1;
                ferr_cyc = cyc;
            end
            if (32'(tick) + 32'(perr) + 32'(ferr) > 32'd1) n_multi = n_multi + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    int fall_cyc = 0;

    // Drive the first nbits bits of a frame; optional 2-cycle ps2c glitch before bit 'glitch'.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch);
        for (int i = 0; i < nbits; i++) begin
            if (i == glitch) begin
                wait_clk(5);
                ps2c = 1'b0;
                wait_clk(2);
                ps2c = 1'b1;
                wait_clk(3);
            end else begin
                wait_clk(HP / 2);
            end
            ps2d = bits[i];
            wait_clk(HP / 2);
            ps2c     = 1'b0;
            fall_cyc = cyc;
            wait_clk(HP);
            ps2c = 1'b1;
        end
        wait_clk(HP / 2);
        ps2d = 1'b1;
    endtask

    logic [7:0] exp_byte = 8'h00;

    // Send one full frame and compare against the frame-level rules.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic par,
                             input logic stop, input logic en, input int glitch);
        int t0, p0, f0, lat;
        int ones;
        bit exp_t, exp_p, exp_f;
        ones  = 0;
        for (int b = 0; b < 8; b++) ones = ones + int'(d[b]);
        ones  = ones + int'(par);
        exp_t = 1'b0;
        exp_p = 1'b0;
        exp_f = 1'b0;
        if (en) begin
            if (!stop)              exp_f = 1'b1;
            else if (ones % 2 == 0) exp_p = 1'b1;
            else                    exp_t = 1'b1;
        end
        rx_en = en;
        t0 = n_tick;
        p0 = n_perr;
        f0 = n_ferr;
        send_bits({stop, par, d, 1'b0}, 11, glitch);
        wait_clk(30);
        chk({tag, "/ticks"}, 32'(n_tick - t0), 32'(exp_t));
        chk({tag, "/perr"},  32'(n_perr - p0), 32'(exp_p));
        chk({tag, "/ferr"},  32'(n_ferr - f0), 32'(exp_f));
        if (exp_t) begin
            exp_byte = d;
            lat = tick_cyc - fall_cyc;
            chk({tag, "/tick_byte"}, 32'(tick_byte), 32'(d));
            chk({tag, "/latency_ok"}, 32'(lat >= 3 && lat <= 14), 32'd1);
        end
        chk({tag, "/byte"}, 32'(byte_dato), 32'(exp_byte));
        chk({tag, "/busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, t0, p0, lat;
        logic [7:0] d;
        logic par, stop, en;
        int gl;

        rst   = 1'b1;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        rx_en = 1'b0;
        wait_clk(5);
        chk("rst/byte", 32'(byte_dato), 32'd0);
        chk("rst/tick", 32'(tick), 32'd0);
        chk("rst/perr", 32'(perr), 32'd0);
        chk("rst/ferr", 32'(ferr), 32'd0);
        chk("rst/busy", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_clk(10);

        run_frame("s1",  8'h1C, 1'b0, 1'b1, 1'b1, -1);
        run_frame("s2a", 8'hF0, 1'b1, 1'b1, 1'b1, -1);
        run_frame("s2b", 8'h1C, 1'b0, 1'b1, 1'b1, -1);
        run_frame("s3",  8'h1C, 1'b1, 1'b1, 1'b1, -1);
        run_frame("s4",  8'h29, 1'b0, 1'b0, 1'b1, -1);
        run_frame("s5",  8'h29, 1'b0, 1'b1, 1'b1, 4);

        // Timeout: start plus 4 data bits, then the clock stays high.
        rx_en = 1'b1;
        f0 = n_ferr;
        t0 = n_tick;
        send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 5, -1);
        wait_clk(250);
        lat = ferr_cyc - fall_cyc;
        chk("s6/ferr", 32'(n_ferr - f0), 32'd1);
        chk("s6/ticks", 32'(n_tick - t0), 32'd0);
        chk("s6/ferr_time_ok", 32'(lat >= TO && lat <= TO + 15), 32'd1);
        chk("s6/busy", 32'(busy), 32'd0);
        run_frame("s6b", 8'h29, 1'b0, 1'b1, 1'b1, -1);

        // Reset mid-frame discards the partial frame without any pulse.
        t0 = n_tick;
        p0 = n_perr;
        f0 = n_ferr;
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 4, -1);
        chk("s7/busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("s7/rst_byte", 32'(byte_dato), 32'd0);
        chk("s7/rst_busy", 32'(busy), 32'd0);
        chk("s7/rst_pulses", 32'(tick) + 32'(perr) + 32'(ferr), 32'd0);
        exp_byte = 8'h00;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(50);
        chk("s7/no_pulse", 32'((n_tick - t0) + (n_perr - p0) + (n_ferr - f0)), 32'd0);
        run_frame("s7a", 8'h1C, 1'b0, 1'b1, 1'b1, -1);
        run_frame("s7b", 8'h1C, 1'b0, 1'b1, 1'b0, -1);

        // Random frames: mostly good, some parity/stop corruption, rx_en and glitches.
        for (int k = 0; k < 24; k++) begin
            d    = 8'($urandom);
            par  = ~(^d);
            if ($urandom_range(0, 3) == 0) par = ~par;
            stop = ($urandom_range(0, 7) != 0);
            en   = ($urandom_range(0, 7) != 0);
            gl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1;
            run_frame($sformatf("rnd%0d", k), d, par, stop, en, gl);
        end

        chk("pulse_exclusive", 32'(n_multi), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
